// File: rtl/vga_sync.sv
// Purpose: 640x480@60 VGA timing generator (x/y coordinates, hsync/vsync, video_on, pixel strobe).
// Latency: sync/video_on are pre-decoded from next-state counters, so they align with x/y (0 cycles).
// Backpressure: none; free-running. Optional VGA_PIX_DIV_EN builds a /CLK_DIV pixel clock-enable.
module vga_sync #(
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);
  localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

  // The divider needs at least two states to produce a strobe narrower than the clock.
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("vga_sync: CLK_DIV must be >= 2");
  end

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;

`ifdef VGA_PIX_DIV_EN
  localparam int                 DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  // Divider next state: count 0..CLK_DIV-1 and wrap.
  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign pixel_tick = (div_q == DIV_LAST);
`else
  // clk is already the pixel clock: every edge is a pixel edge.
  assign pixel_tick = 1'b1;
`endif

  // Counter next state plus sync/blank decode of that next state.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pixel_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    hsync_d    = !((h_d >= HS_START) && (h_d <= HS_END));
    vsync_d    = !((v_d >= VS_START) && (v_d <= VS_END));
    video_on_d = (h_d < H_VIS) && (v_d < V_VIS);
  end

  // Counter and decoded-output registers; reset state is the (0,0) pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q        <= '0;
      v_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign x           = h_q;
  assign y           = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = (h_q == '0) && (v_q == '0);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: reduced vertical timing keeps a full frame short; horizontal timing is the real 800-pixel line.
// Reference: pixel position is derived arithmetically from the number of clock edges since reset release.
// Randomized run lengths and reset pulses, including an asynchronous reset mid-frame.
module tb_vga_sync;

  localparam int H_DISP = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_DISP = 6,   V_FP = 2,  V_SYNC = 2,  V_BP = 2;
  localparam int H_TOT  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_DISP + V_FP + V_SYNC + V_BP;
`ifdef VGA_PIX_DIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x, y;
  logic       hsync, vsync, video_on, pixel_tick, frame_start;

  int n_chk  = 0;
  int n_fail = 0;
  int n_clk  = 0;   // rising edges seen with rst_n high since the last reset
  int frames = 0;

  vga_sync #(
    .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pixel_tick(pixel_tick), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (clk edges since reset %0d)", tag, obs, exp, n_clk);
    end
  endtask

  // Reference: pixel index = edges / DIV; position is that index taken modulo line and frame lengths.
  task automatic check_all();
    int t, eh, ev;
    logic etick;
    t     = n_clk / DIV;
    eh    = t % H_TOT;
    ev    = (t / H_TOT) % V_TOT;
    etick = (DIV == 1) ? 1'b1 : ((n_clk % DIV) == DIV - 1);
    chk("x", 32'(x), 32'(eh));
    chk("y", 32'(y), 32'(ev));
    chk("hsync", 32'(hsync), 32'(!(eh >= 656 && eh <= 751)));
    chk("vsync", 32'(vsync), 32'(!(ev >= V_DISP + V_FP && ev < V_DISP + V_FP + V_SYNC)));
    chk("video_on", 32'(video_on), 32'(eh < 640 && ev < V_DISP));
    chk("pixel_tick", 32'(pixel_tick), 32'(etick));
    chk("frame_start", 32'(frame_start), 32'(eh == 0 && ev == 0));
  endtask

  // One clock: advance the reference on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) n_clk++;
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must fall back at once.
  task automatic pulse_reset(input int hold);
    rst_n = 1'b0;
    n_clk = 0;
    #1;
    check_all();
    run(hold);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    check_all();
    run(3);
    rst_n = 1'b1;

    // Past one full frame so the (799, V_TOT-1) -> (0,0) wrap and frame restart are covered.
    run(DIV * H_TOT * V_TOT + DIV * H_TOT + 5);
    chk("frame_wrapped", 32'(frames >= 1), 32'd1);

    // Reset in the middle of the frame at (300, 3).
    pulse_reset(2);
    run(DIV * (3 * H_TOT + 300));
    chk("pre_reset_x", 32'(x), 32'd300);
    chk("pre_reset_y", 32'(y), 32'd3);
    pulse_reset(1 + $urandom_range(4));
    run(DIV * 2 + 1);

    // Random run lengths interrupted by random reset pulses.
    for (int k = 0; k < 4; k++) begin
      run(1 + $urandom_range(3000));
      pulse_reset(1 + $urandom_range(4));
    end
    run(DIV * H_TOT + 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Count frame starts entered by counting (not by reset) to confirm the frame wrap was reached.
  always @(posedge clk) begin
    if (rst_n && pixel_tick && x == 10'(H_TOT - 1) && y == 10'(V_TOT - 1)) frames <= frames + 1;
  end

endmodule
